// File: rtl/beep_decoder.sv
// beep_decoder: recovers light colour and fault status from the buzzer
// beep waveform by measuring burst lengths, with two-burst confirmation.
module beep_decoder #(
  parameter int CNT_W      = 16,
  parameter int TONE_GAP   = 16,
  parameter int T1         = 256,
  parameter int T2         = 1024,
  parameter int T3         = 4096,
  parameter int SILENT_MAX = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beep_in,
  output logic [1:0] color_out,
  output logic       fault_out,
  output logic       silent,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(TONE_GAP);
  localparam logic [CNT_W-1:0] T1_C   = CNT_W'(T1);
  localparam logic [CNT_W-1:0] T2_C   = CNT_W'(T2);
  localparam logic [CNT_W-1:0] T3P1_C = CNT_W'(T3 + 1);
  localparam logic [CNT_W-1:0] SIL_C  = CNT_W'(SILENT_MAX);

  logic [2:0]       sync_q;
  logic             beep_edge;
  logic [CNT_W-1:0] gap_cnt;
  logic             gap_hit;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] on_cnt_q;
  logic [CNT_W-1:0] on_cnt_d;
  logic [CNT_W-1:0] off_cnt_q;
  logic [CNT_W-1:0] off_cnt_d;
  logic             prev_ok_q;
  logic             prev_ok_d;
  logic [1:0]       prev_class_q;
  logic [1:0]       prev_class_d;

  logic [1:0]       color_d;
  logic             fault_d;
  logic             silent_d;
  logic             valid_d;

  logic [1:0]       burst_class;
  logic             is_fault;

  // Synchronizer plus one extra stage; left unreset so a line held high
  // through reset does not produce a false edge afterwards.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[1:0], beep_in};
  end

  assign beep_edge = sync_q[2] ^ sync_q[1];
  assign gap_hit   = (gap_cnt == GAP_C);

  // Cycles since the last input edge, saturating at the tone gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (beep_edge) begin
      gap_cnt <= '0;
    end else if (gap_cnt < GAP_C) begin
      gap_cnt <= gap_cnt + ONE_C;
    end
  end

  // Classify the burst measured so far by its length.
  always_comb begin
    burst_class = 2'b01;
    unique case (1'b1)
      (on_cnt_q <= T1_C):
        burst_class = 2'b11;
      (on_cnt_q > T1_C) && (on_cnt_q <= T2_C):
        burst_class = 2'b10;
      (on_cnt_q > T2_C):
        burst_class = 2'b01;
      default:
        burst_class = 2'b01;
    endcase
  end

  // Next-state and output decode for the burst FSM.
  always_comb begin
    state_d      = state_q;
    on_cnt_d     = on_cnt_q;
    off_cnt_d    = off_cnt_q;
    prev_ok_d    = prev_ok_q;
    prev_class_d = prev_class_q;
    color_d      = color_out;
    fault_d      = fault_out;
    silent_d     = silent;
    is_fault     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (beep_edge) begin
          state_d  = ON;
          on_cnt_d = ONE_C;
        end
      end

      ON: begin
        if (on_cnt_q < T3P1_C) begin
          on_cnt_d = on_cnt_q + ONE_C;
        end
        is_fault = (on_cnt_q == T3P1_C);
        if (is_fault && !fault_out) begin
          fault_d   = 1'b1;
          color_d   = 2'b00;
          silent_d  = 1'b0;
          prev_ok_d = 1'b0;
        end
        if (!beep_edge && gap_hit) begin
          state_d   = OFF;
          off_cnt_d = ONE_C;
          if (is_fault) begin
            prev_ok_d = 1'b0;
          end else begin
            if (prev_ok_q && (burst_class == prev_class_q)) begin
              color_d  = burst_class;
              fault_d  = 1'b0;
              silent_d = 1'b0;
            end
            prev_class_d = burst_class;
            prev_ok_d    = 1'b1;
          end
        end
      end

      OFF: begin
        if (off_cnt_q < SIL_C) begin
          off_cnt_d = off_cnt_q + ONE_C;
        end
        if (beep_edge) begin
          state_d  = ON;
          on_cnt_d = ONE_C;
        end else if (off_cnt_q == SIL_C) begin
          state_d   = IDLE;
          silent_d  = 1'b1;
          color_d   = 2'b00;
          fault_d   = 1'b0;
          prev_ok_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = ({color_d, fault_d, silent_d}
            != {color_out, fault_out, silent});
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      on_cnt_q     <= '0;
      off_cnt_q    <= '0;
      prev_ok_q    <= 1'b0;
      prev_class_q <= 2'b00;
      color_out    <= 2'b00;
      fault_out    <= 1'b0;
      silent       <= 1'b1;
      valid        <= 1'b0;
    end else begin
      state_q      <= state_d;
      on_cnt_q     <= on_cnt_d;
      off_cnt_q    <= off_cnt_d;
      prev_ok_q    <= prev_ok_d;
      prev_class_q <= prev_class_d;
      color_out    <= color_d;
      fault_out    <= fault_d;
      silent       <= silent_d;
      valid        <= valid_d;
    end
  end

endmodule
